// File: rtl/bus_addr_receiver_pkg.sv
// Shared CPU datapath types used by the bus address receiver and its interface.
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [7:0]        byte_t;

  typedef enum logic {
    IDLE,
    HAVE_LOW
  } addr_rx_state_t;

endpackage

// File: rtl/bus_addr_receiver_if.sv
// Data-bus side of the address receiver: load/inc strobes in, assembled address out.
interface bus_addr_receiver_if;

  cpu_pkg::byte_t i_bus;
  logic           i_load;
  logic           i_loadLow;
  logic           i_loadHigh;
  logic           i_inc;
  logic           i_abort;
  cpu_pkg::addr_t o_addr;
  logic           o_pending;
  logic           o_valid;
  logic           o_carry;

  modport master (
    output i_bus, i_load, i_loadLow, i_loadHigh, i_inc, i_abort,
    input  o_addr, o_pending, o_valid, o_carry
  );

  modport slave (
    input  i_bus, i_load, i_loadLow, i_loadHigh, i_inc, i_abort,
    output o_addr, o_pending, o_valid, o_carry
  );

endinterface

// File: rtl/bus_addr_receiver.sv
// Assembles bytes from the shared data bus into the 16-bit memory address register,
// with sequenced two-beat loads, direct half loads and post-increment.
module bus_addr_receiver
  import cpu_pkg::*;
#(
  parameter addr_t RESET_ADDR = 16'h0000,
  parameter bit    WRAP_FLAG  = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  bus_addr_receiver_if.slave  bus
);

  addr_rx_state_t state_q, state_d;
  byte_t          stage_q, stage_d;
  addr_t          addr_q,  addr_d;
  logic           valid_q, valid_d;
  logic           await_hi_q, await_hi_d;
  logic           carry_q, carry_d;
  logic           complete;
  logic [ADDR_W:0] inc_sum;

  assign complete = (state_q == HAVE_LOW) && bus.i_load;
  assign inc_sum  = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      addr_q     <= RESET_ADDR;
      valid_q    <= 1'b1;
      await_hi_q <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      await_hi_q <= await_hi_d;
      carry_q    <= carry_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    await_hi_d = await_hi_q;
    carry_d    = 1'b0;

    // Address update priority: sequenced completion, direct loads, increment.
    // await_hi_q only matters while valid_q is low: it names the half still missing.
    if (complete) begin
      addr_d  = {bus.i_bus, stage_q};
      valid_d = 1'b1;
    end else if (bus.i_loadLow && bus.i_loadHigh) begin
      addr_d  = {bus.i_bus, bus.i_bus};
      valid_d = 1'b1;
    end else if (bus.i_loadLow) begin
      addr_d[7:0] = bus.i_bus;
      valid_d     = !valid_q && !await_hi_q;
      await_hi_d  = 1'b1;
    end else if (bus.i_loadHigh) begin
      addr_d[ADDR_W-1:8] = bus.i_bus;
      valid_d            = !valid_q && await_hi_q;
      await_hi_d         = 1'b0;
    end else if (bus.i_inc) begin
      addr_d  = inc_sum[ADDR_W-1:0];
      carry_d = WRAP_FLAG && inc_sum[ADDR_W];
    end

    case (state_q)
      IDLE: begin
        if (bus.i_load) begin
          stage_d = bus.i_bus;
          state_d = HAVE_LOW;
        end
      end
      HAVE_LOW: begin
        if (bus.i_load || bus.i_abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_addr    = addr_q;
  assign bus.o_pending = (state_q == HAVE_LOW);
  assign bus.o_valid   = valid_q;
  assign bus.o_carry   = carry_q;

endmodule

// File: tb/tb_bus_addr_receiver.sv
// Self-checking bench for bus_addr_receiver: directed vector table plus randomized
// traffic compared against a behavioural model of the address register.
module tb_bus_addr_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_addr_receiver_if bif ();

  bus_addr_receiver #(
    .RESET_ADDR (16'h0000),
    .WRAP_FLAG  (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bif)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  bus;
    logic        load, lo, hi, inc, abort;
    logic [15:0] e_addr;
    logic        e_pend, e_valid, e_carry;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int   m_addr;
  bit   m_pending;
  int   m_stage;
  bit   m_valid;
  bit   m_carry;
  bit   m_have_lo, m_have_hi;

  function automatic vec_t mkv(logic r, logic [7:0] b, logic ld, logic l, logic h,
                               logic i, logic a, logic [15:0] ea, logic ep,
                               logic ev, logic ec);
    vec_t v;
    v.rst = r; v.bus = b; v.load = ld; v.lo = l; v.hi = h; v.inc = i; v.abort = a;
    v.e_addr = ea; v.e_pend = ep; v.e_valid = ev; v.e_carry = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] b, input logic ld, input logic l,
                       input logic h, input logic i, input logic a);
    rst = r; bif.i_bus = b; bif.i_load = ld; bif.i_loadLow = l;
    bif.i_loadHigh = h; bif.i_inc = i; bif.i_abort = a;
  endtask

  // Model update, written from the behavioural rules.
  task automatic model_step(input logic r, input logic [7:0] b, input logic ld,
                            input logic l, input logic h, input logic i, input logic a);
    bit was_pending;
    if (r) begin
      m_addr = 0; m_pending = 0; m_stage = 0; m_valid = 1; m_carry = 0;
      m_have_lo = 1; m_have_hi = 1;
      return;
    end
    was_pending = m_pending;
    m_carry = 0;
    if (was_pending && ld) begin
      m_addr = int'(b) * 256 + m_stage;
      m_valid = 1;
    end else if (l && h) begin
      m_addr = int'(b) * 257;
      m_valid = 1;
    end else if (l || h) begin
      if (m_valid) begin m_have_lo = 0; m_have_hi = 0; end
      if (l) begin m_addr = (m_addr / 256) * 256 + int'(b); m_have_lo = 1; end
      if (h) begin m_addr = int'(b) * 256 + (m_addr % 256); m_have_hi = 1; end
      m_valid = m_have_lo && m_have_hi;
    end else if (i) begin
      m_carry = (m_addr == 65535);
      m_addr  = (m_addr + 1) % 65536;
    end
    if (!was_pending && ld) begin
      m_stage = int'(b); m_pending = 1;
    end else if (was_pending && (ld || a)) begin
      m_pending = 0;
    end
  endtask

  initial begin
    drive(1'b1, 8'h00, 0, 0, 0, 0, 0);

    //              rst bus   ld lo hi in ab  addr     p  v  c
    tbl[0]  = mkv(1, 8'h00, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
    tbl[1]  = mkv(0, 8'h34, 1, 0, 0, 0, 0, 16'h0000, 1, 1, 0);
    tbl[2]  = mkv(0, 8'h12, 1, 0, 0, 0, 0, 16'h1234, 0, 1, 0);
    tbl[3]  = mkv(0, 8'h00, 0, 0, 0, 0, 0, 16'h1234, 0, 1, 0);
    tbl[4]  = mkv(0, 8'hAA, 0, 1, 0, 0, 0, 16'h12AA, 0, 0, 0);
    tbl[5]  = mkv(0, 8'h55, 0, 0, 1, 0, 0, 16'h55AA, 0, 1, 0);
    tbl[6]  = mkv(0, 8'hFE, 1, 0, 0, 0, 0, 16'h55AA, 1, 1, 0);
    tbl[7]  = mkv(0, 8'hFF, 1, 0, 0, 0, 0, 16'hFFFE, 0, 1, 0);
    tbl[8]  = mkv(0, 8'h00, 0, 0, 0, 1, 0, 16'hFFFF, 0, 1, 0);
    tbl[9]  = mkv(0, 8'h00, 0, 0, 0, 1, 0, 16'h0000, 0, 1, 1);
    tbl[10] = mkv(0, 8'h00, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
    tbl[11] = mkv(0, 8'h77, 1, 0, 0, 0, 0, 16'h0000, 1, 1, 0);
    tbl[12] = mkv(0, 8'h00, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 0);
    tbl[13] = mkv(0, 8'h01, 1, 0, 0, 0, 0, 16'h0000, 1, 1, 0);
    tbl[14] = mkv(0, 8'h02, 1, 0, 0, 0, 0, 16'h0201, 0, 1, 0);
    tbl[15] = mkv(0, 8'h10, 1, 0, 0, 0, 0, 16'h0201, 1, 1, 0);
    tbl[16] = mkv(0, 8'h20, 1, 1, 0, 1, 0, 16'h2010, 0, 1, 0);
    tbl[17] = mkv(0, 8'h00, 0, 0, 0, 0, 1, 16'h2010, 0, 1, 0);
    tbl[18] = mkv(0, 8'hAB, 1, 0, 0, 1, 0, 16'h2011, 1, 1, 0);
    tbl[19] = mkv(0, 8'hCD, 1, 0, 0, 0, 1, 16'hCDAB, 0, 1, 0);
    tbl[20] = mkv(0, 8'h99, 1, 0, 0, 0, 0, 16'hCDAB, 1, 1, 0);
    tbl[21] = mkv(1, 8'h11, 1, 0, 0, 1, 0, 16'h0000, 0, 1, 0);
    tbl[22] = mkv(0, 8'h00, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 0);
    tbl[23] = mkv(0, 8'h5A, 0, 1, 1, 0, 0, 16'h5A5A, 0, 1, 0);
    tbl[24] = mkv(0, 8'h3C, 0, 0, 1, 0, 0, 16'h3C5A, 0, 0, 0);
    tbl[25] = mkv(0, 8'h3D, 0, 0, 1, 0, 0, 16'h3D5A, 0, 0, 0);
    tbl[26] = mkv(0, 8'h00, 0, 0, 0, 1, 0, 16'h3D5B, 0, 0, 0);
    tbl[27] = mkv(0, 8'h00, 0, 1, 0, 0, 0, 16'h3D00, 0, 1, 0);
    tbl[28] = mkv(0, 8'h44, 1, 0, 0, 0, 0, 16'h3D00, 1, 1, 0);
    tbl[29] = mkv(0, 8'h66, 0, 1, 0, 0, 0, 16'h3D66, 1, 0, 0);
    tbl[30] = mkv(0, 8'h88, 1, 0, 0, 0, 0, 16'h8844, 0, 1, 0);

    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].rst, tbl[k].bus, tbl[k].load, tbl[k].lo, tbl[k].hi,
            tbl[k].inc, tbl[k].abort);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d addr", k),  bif.o_addr,           tbl[k].e_addr);
      chk($sformatf("v%0d pend", k),  16'(bif.o_pending),   16'(tbl[k].e_pend));
      chk($sformatf("v%0d valid", k), 16'(bif.o_valid),     16'(tbl[k].e_valid));
      chk($sformatf("v%0d carry", k), 16'(bif.o_carry),     16'(tbl[k].e_carry));
    end

    // Hand-written: reset mid-sequence after a partial direct load and a wrap.
    drive(0, 8'hFF, 0, 1, 1, 0, 0); @(posedge clk); #1;
    drive(0, 8'h00, 0, 0, 0, 1, 0); @(posedge clk); #1;
    chk("wrap carry", 16'(bif.o_carry), 16'd1);
    drive(0, 8'h21, 0, 0, 1, 0, 0); @(posedge clk); #1;
    chk("wrap then hi valid", 16'(bif.o_valid), 16'd0);
    drive(0, 8'h42, 1, 0, 0, 0, 0); @(posedge clk); #1;
    drive(1, 8'h43, 1, 0, 0, 1, 0); @(posedge clk); #1;
    chk("rst addr",  bif.o_addr, 16'h0000);
    chk("rst pend",  16'(bif.o_pending), 16'd0);
    chk("rst valid", 16'(bif.o_valid), 16'd1);
    chk("rst carry", 16'(bif.o_carry), 16'd0);

    // Randomized traffic against the model.
    model_step(1, 8'h00, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, ld, l, h, i, a;
      logic [7:0] b;
      r  = ($urandom_range(0, 99) == 0);
      b  = 8'($urandom);
      ld = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 5) == 0);
      h  = ($urandom_range(0, 5) == 0);
      i  = ($urandom_range(0, 1) == 0);
      a  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) begin
        // Steer toward the wrap boundary.
        r = 0; ld = 0; l = 1; h = 1; i = 0; b = 8'hFF;
      end
      drive(r, b, ld, l, h, i, a);
      @(posedge clk);
      #1;
      model_step(r, b, ld, l, h, i, a);
      chk("rnd addr",  bif.o_addr,          16'(m_addr));
      chk("rnd pend",  16'(bif.o_pending),  16'(m_pending));
      chk("rnd valid", 16'(bif.o_valid),    16'(m_valid));
      chk("rnd carry", 16'(bif.o_carry),    16'(m_carry));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_addr_receiver.md
Name: bus_addr_receiver

Overview:
- Receiving end of the 8-bit shared data bus.
- Captures bytes that register sets drive onto the bus, and assembles them into a 16-bit address register for the memory address path.
- Supports a two-beat sequenced load (low byte then high byte), direct half loads, and post-increment for sequential memory access.
- Sits between the data bus and the memory address inputs; its output is never driven back onto the bus.

Parameters:
RESET_ADDR, 16'h0000, value of o_addr after reset
WRAP_FLAG, 1, when 1 o_carry pulses on an increment wrap from 16'hFFFF to 16'h0000; when 0 o_carry is tied 0

Ports:
i_clk  input  1  system clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_bus  input  8  shared data bus value, sampled on the rising edge
i_load  input  1  sequenced load strobe; first beat = low byte, second beat = high byte
i_loadLow  input  1  direct load of o_addr[7:0] from i_bus
i_loadHigh  input  1  direct load of o_addr[15:8] from i_bus
i_inc  input  1  post-increment o_addr by 1
i_abort  input  1  discard a half-finished sequenced load
o_addr  output  16  current address
o_pending  output  1  high while the low byte is staged and the high byte is awaited
o_valid  output  1  high when o_addr holds a complete, unmodified-by-partial-load address
o_carry  output  1  one-cycle pulse on increment wrap

Behaviour:
- Reset (synchronous, active-high) overrides everything. Post-reset values:
  - o_addr = RESET_ADDR, o_pending = 0, o_valid = 1, o_carry = 0
  - FSM in IDLE; staging byte = 0
- FSM states: IDLE and HAVE_LOW. o_pending = (state == HAVE_LOW), registered.
- IDLE + i_load:
  - staging <= i_bus; go to HAVE_LOW.
  - o_addr is unchanged; o_valid stays at its current value.
- HAVE_LOW + i_load:
  - o_addr <= {i_bus, staging}; o_valid <= 1; go to IDLE.
  - Latency: the new address is visible on the cycle after the second beat.
- HAVE_LOW + i_abort (and no i_load): go to IDLE; staging discarded; o_addr unchanged.
  - In HAVE_LOW, i_load wins over i_abort when both are asserted.
  - i_abort in IDLE is a no-op.
- Direct loads (i_loadLow, i_loadHigh):
  - Affect only the named half; o_valid <= 0 until the other half is written by a direct load, a sequenced load, or reset.
  - Both asserted together: both halves <= i_bus, o_valid <= 1.
  - Do not change FSM state or staging.
- i_inc: o_addr <= o_addr + 1, modulo 2^16. At 16'hFFFF the result is 16'h0000 and o_carry pulses for 1 cycle (if WRAP_FLAG).
- Priority in one cycle: reset > completing sequenced load (HAVE_LOW + i_load) > direct loads > i_inc.
  - The lower-priority o_addr update is dropped, not deferred.
  - i_inc with a first-beat i_load (IDLE): both take effect (increment o_addr, stage byte).
  - i_inc does not alter o_valid.
- o_carry is 0 on every cycle without a wrapping increment.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (cpu_pkg):
  - typedef addr_t (16 bits), byte_t (8 bits)
  - enum addr_rx_state_t {IDLE, HAVE_LOW}
  - constant ADDR_W = 16
- No sub-module. The incrementer is a single adder with carry-out; the staging byte is a plain register. A single module keeps the priority logic in one always block.

Test Plan:
1. Reset, then IDLE: i_load with i_bus=8'h34, next cycle i_load with i_bus=8'h12 -> o_pending=1 for exactly 1 cycle, then o_addr=16'h1234, o_valid=1.
2. o_addr=16'hFFFE, i_inc for 2 cycles -> o_addr 16'hFFFF, then 16'h0000; o_carry=1 only on the second update.
3. o_addr=16'h1234, i_loadLow with i_bus=8'hAA -> o_addr=16'h12AA, o_valid=0. Then i_loadHigh with i_bus=8'h55 -> o_addr=16'h55AA, o_valid=1.
4. i_load with i_bus=8'h77, then i_abort, then i_load with 8'h01 and i_load with 8'h02 -> aborted byte discarded, o_addr=16'h0201.
5. HAVE_LOW with staged 8'h10, same cycle i_load (i_bus=8'h20), i_inc and i_loadLow -> o_addr=16'h2010; inc and direct load dropped.
6. Reset asserted mid-sequence in HAVE_LOW -> next cycle o_pending=0, o_addr=RESET_ADDR, o_valid=1, o_carry=0.
